// File: rtl/game_scoreboard_if.sv
// Bundle between the memory-game FSM / display and the scoreboard.
//   result, new_game         : round verdict and restart request (into scoreboard)
//   score, high_score        : BCD scores, tens in [7:4]
//   lives, level, game_over  : game status
//   seg, an                  : active-low 7-segment cathodes {g..a} and anodes
interface game_scoreboard_if;
  logic [1:0] result;
  logic       new_game;
  logic [7:0] score;
  logic [7:0] high_score;
  logic [1:0] lives;
  logic [2:0] level;
  logic       game_over;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output result, new_game,
    input  score, high_score, lives, level, game_over, seg, an
  );

  modport slave (
    input  result, new_game,
    output score, high_score, lives, level, game_over, seg, an
  );
endinterface

// File: rtl/game_scoreboard.sv
// Score / lives / level keeper for the memory game with a multiplexed
// 4-digit 7-segment display.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : game_scoreboard_if.slave (round verdicts in, status and display out)
module game_scoreboard #(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned WINS_PER_LEVEL = 4,
  parameter int unsigned SCAN_DIV       = 16
) (
  input logic              clk,
  input logic              reset,
  game_scoreboard_if.slave bus
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);

  localparam logic [0:0] PLAY = 1'b0;
  localparam logic [0:0] OVER = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        result_q;
  logic              armed_q;
  logic [7:0]        score_q, score_d;
  logic [7:0]        high_q, high_d;
  logic [1:0]        lives_q, lives_d;
  logic [2:0]        level_q, level_d;
  logic [3:0]        streak_q, streak_d;
  logic              game_over_q;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        digit_c;
  logic              round_ev_c;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // A round event is a 0 -> nonzero transition, and only once a zero has
  // been sampled since reset (armed_q), so a verdict held across reset is ignored.
  assign round_ev_c = armed_q && (result_q == 2'd0) && (bus.result != 2'd0);

  // Game state next-state logic
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    high_d   = high_q;
    lives_d  = lives_q;
    level_d  = level_q;
    streak_d = streak_q;
    if (bus.new_game) begin
      state_d  = PLAY;
      score_d  = 8'h00;
      lives_d  = 2'(LIVES_INIT);
      level_d  = 3'd0;
      streak_d = 4'd0;
    end else if (round_ev_c && state_q == PLAY) begin
      case (bus.result)
        2'd2: begin
          if (score_q != 8'h99) begin
            if (score_q[3:0] == 4'd9) score_d = {score_q[7:4] + 4'd1, 4'd0};
            else                      score_d = {score_q[7:4], score_q[3:0] + 4'd1};
          end
          if (32'(streak_q) + 32'd1 >= WINS_PER_LEVEL) begin
            streak_d = 4'd0;
            if (level_q != 3'd7) level_d = level_q + 3'd1;
          end else begin
            streak_d = streak_q + 4'd1;
          end
        end
        2'd1: begin
          streak_d = 4'd0;
          lives_d  = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_d = OVER;
            // Packed BCD orders the same as binary, so a plain compare works.
            if (score_q > high_q) high_d = score_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Display scan and digit selection; an/seg are registered together.
  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
    case (idx_d)
      2'd0:    digit_c = (state_q == OVER) ? high_q[3:0] : score_q[3:0];
      2'd1:    digit_c = (state_q == OVER) ? high_q[7:4] : score_q[7:4];
      2'd2:    digit_c = {2'b00, lives_q};
      default: digit_c = {1'b0, level_q};
    endcase
    an_d  = ~(4'b0001 << idx_d);
    seg_d = hex7(digit_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PLAY;
      result_q    <= 2'd0;
      armed_q     <= 1'b0;
      score_q     <= 8'h00;
      high_q      <= 8'h00;
      lives_q     <= 2'(LIVES_INIT);
      level_q     <= 3'd0;
      streak_q    <= 4'd0;
      game_over_q <= 1'b0;
      scan_q      <= '0;
      idx_q       <= 2'd0;
      an_q        <= 4'b1110;
      seg_q       <= 7'b1000000;
    end else begin
      state_q     <= state_d;
      result_q    <= bus.result;
      if (bus.result == 2'd0) armed_q <= 1'b1;
      score_q     <= score_d;
      high_q      <= high_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      streak_q    <= streak_d;
      game_over_q <= (state_d == OVER);
      scan_q      <= scan_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.score      = score_q;
  assign bus.high_score = high_q;
  assign bus.lives      = lives_q;
  assign bus.level      = level_q;
  assign bus.game_over  = game_over_q;
  assign bus.seg        = seg_q;
  assign bus.an         = an_q;

endmodule

// File: tb/tb_game_scoreboard.sv
// Randomized + directed bench for game_scoreboard against a decimal-integer
// game model; every cycle all outputs are compared.
module tb_game_scoreboard;

  localparam int LIVES_INIT = 3;
  localparam int WINS       = 4;
  localparam int SCAN_DIV   = 4;

  logic clk;
  logic reset;
  game_scoreboard_if bus();

  game_scoreboard #(
    .LIVES_INIT(LIVES_INIT),
    .WINS_PER_LEVEL(WINS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference game state as plain decimal integers
  int m_score, m_hs, m_lives, m_level, m_streak, m_n, m_prev;
  bit m_over, m_armed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v & 15];
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic check_state();
    chk("score", bus.score, bcd(m_score));
    chk("high_score", bus.high_score, bcd(m_hs));
    chk("lives", bus.lives, m_lives);
    chk("level", bus.level, m_level);
    chk("game_over", bus.game_over, m_over);
  endtask

  // Assert reset at posedge+2, check, release at posedge+4 (before next negedge)
  task automatic do_reset();
    #1 reset = 1'b1;
    m_score = 0; m_hs = 0; m_lives = LIVES_INIT; m_level = 0; m_streak = 0;
    m_over = 0; m_armed = 0; m_prev = 0; m_n = 0;
    #1;
    check_state();
    chk("rst_an", bus.an, 4'b1110);
    chk("rst_seg", bus.seg, 7'b1000000);
    #1 reset = 1'b0;
  endtask

  task automatic step(input int res, input bit ng);
    int idx, d;
    bit ev;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    @(negedge clk);
    bus.result   = 2'(res);
    bus.new_game = ng;
    // display after this edge reflects the game state before it
    m_n++;
    idx = (m_n / SCAN_DIV) % 4;
    case (idx)
      0: d = m_over ? m_hs % 10 : m_score % 10;
      1: d = m_over ? m_hs / 10 : m_score / 10;
      2: d = m_lives;
      default: d = m_level;
    endcase
    exp_seg = seg_of(d);
    exp_an  = 4'hF & ~(4'(1) << idx);
    ev = m_armed && (m_prev == 0) && (res != 0);
    if (ng) begin
      m_score = 0; m_lives = LIVES_INIT; m_level = 0; m_streak = 0; m_over = 0;
    end else if (ev && !m_over) begin
      if (res == 2) begin
        if (m_score < 99) m_score++;
        m_streak++;
        if (m_streak == WINS) begin
          m_streak = 0;
          if (m_level < 7) m_level++;
        end
      end else if (res == 1) begin
        m_streak = 0;
        m_lives--;
        if (m_lives == 0) begin
          m_over = 1;
          if (m_score > m_hs) m_hs = m_score;
        end
      end
    end
    m_prev = res;
    if (res == 0) m_armed = 1;
    @(posedge clk);
    #1;
    check_state();
    chk("an", bus.an, exp_an);
    chk("seg", bus.seg, exp_seg);
  endtask

  task automatic pulse(input int res, input int n);
    for (int i = 0; i < n; i++) begin
      step(res, 0);
      step(0, 0);
    end
  endtask

  initial begin
    int r, res;
    bit ng;
    reset = 1'b1;
    bus.result = 2'd0;
    bus.new_game = 1'b0;
    #6;
    do_reset();

    // five correct rounds
    step(0, 0);
    pulse(2, 5);
    chk("five_score", bus.score, 8'h05);
    chk("five_level", bus.level, 3'd1);
    chk("five_lives", bus.lives, 2'd3);

    // held verdict counts once
    @(posedge clk); do_reset();
    step(0, 0);
    for (int i = 0; i < 10; i++) step(2, 0);
    step(0, 0);
    chk("held_score", bus.score, 8'h01);

    // BCD carry and saturation
    step(0, 1);
    pulse(2, 9);
    chk("bcd_09", bus.score, 8'h09);
    pulse(2, 1);
    chk("bcd_10", bus.score, 8'h10);
    pulse(2, 89);
    chk("bcd_99", bus.score, 8'h99);
    pulse(2, 1);
    chk("bcd_sat", bus.score, 8'h99);
    chk("level_sat", bus.level, 3'd7);

    // game over with high score capture, then frozen
    step(0, 1);
    pulse(2, 7);
    pulse(1, 3);
    chk("over_flag", bus.game_over, 1'b1);
    chk("over_lives", bus.lives, 2'd0);
    chk("over_hs", bus.high_score, 8'h07);
    pulse(2, 3);
    chk("over_hold", bus.score, 8'h07);
    for (int i = 0; i < 16; i++) step(0, 0);

    // new_game beats a simultaneous event
    step(2, 1);
    chk("ng_score", bus.score, 8'h00);
    chk("ng_lives", bus.lives, 2'd3);
    chk("ng_over", bus.game_over, 1'b0);
    chk("ng_hs", bus.high_score, 8'h07);

    // lower score does not replace high score; invalid verdict ignored
    step(0, 0);
    pulse(3, 2);
    pulse(2, 2);
    pulse(1, 3);
    chk("hs_keep", bus.high_score, 8'h07);

    // reset with an in-flight verdict held afterwards
    step(0, 1);
    step(0, 0);
    bus.result = 2'd2;
    do_reset();
    for (int i = 0; i < 4; i++) step(2, 0);
    chk("rst_inflight", bus.score, 8'h00);

    // randomized play
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50) res = 0;
      else if (r < 75) res = 2;
      else if (r < 90) res = 1;
      else res = 3;
      ng = ($urandom_range(0, 99) < 3);
      step(res, ng);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_scoreboard.md
GAME_SCOREBOARD -- requirements
Module: game_scoreboard

Interface
REQ-001 Parameter LIVES_INIT, default 3, SHALL set the lives loaded at game start (legal range 1..3).
REQ-002 Parameter WINS_PER_LEVEL, default 4, SHALL set the consecutive correct rounds needed per level-up (legal range 1..15).
REQ-003 Parameter SCAN_DIV, default 16, SHALL set the clk cycles each display digit is held (legal range >=2).
REQ-004 clk  input  1  SHALL be the single rising-edge clock.
REQ-005 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 result  input  2  SHALL be the round verdict from the upstream memory-game FSM: 0 none, 1 incorrect, 2 correct, 3 invalid.
REQ-007 new_game  input  1  SHALL be a synchronous restart request, sampled each clk.
REQ-008 score  output  8  SHALL be the current score as two BCD digits, with tens in [7:4].
REQ-009 high_score  output  8  SHALL be the best completed-game score as two BCD digits.
REQ-010 lives  output  2  SHALL be the remaining lives.
REQ-011 level  output  3  SHALL be the current level.
REQ-012 game_over  output  1  SHALL be high while the FSM is in OVER.
REQ-013 seg  output  7  SHALL be the 7-segment cathodes, active-low, ordered {g,f,e,d,c,b,a}.
REQ-014 an  output  4  SHALL be the digit anodes, active-low, one-hot-zero.

Function
REQ-015 A round event SHALL be detected on the cycle that result changes from 0 to nonzero, using a registered copy of result.
- A result held nonzero SHALL count once only.
- The event SHALL take effect at the next clk edge (one-cycle latency from the result change to updated outputs).
REQ-016 The FSM SHALL have two states: PLAY and OVER.
REQ-017 In PLAY, a correct event (2) SHALL:
- increment score in BCD (09->10, 19->20), saturating at 99;
- increment the streak counter.
REQ-018 When the streak reaches WINS_PER_LEVEL:
- level SHALL increment, saturating at 7;
- streak SHALL clear in the same cycle.
REQ-019 In PLAY, an incorrect event (1) SHALL decrement lives and clear the streak.
REQ-020 An incorrect event with lives==1 SHALL:
- set lives to 0;
- move the FSM to OVER;
- load high_score with score in the same cycle if score > high_score (BCD compare); otherwise high_score is unchanged.
REQ-021 Event value 3 SHALL be ignored in all states.
REQ-022 In OVER, all round events SHALL be ignored; score, lives and level SHALL hold.
REQ-023 new_game in either state SHALL, at the next edge:
- load score=0, lives=LIVES_INIT, level=0, streak=0;
- set the state to PLAY;
- leave high_score unchanged.
REQ-024 If new_game and a round event occur in the same cycle, new_game SHALL win and the event SHALL be discarded.
REQ-025 The scan counter SHALL count 0..SCAN_DIV-1 and wrap.
- On wrap, the digit index SHALL advance 0->1->2->3->0.
- Index i SHALL drive an[i]=0 with all other anodes at 1.
REQ-026 Digit contents:
- digit0 = score units, digit1 = score tens, digit2 = lives, digit3 = level;
- in OVER, digit0 and digit1 SHALL show high_score units and tens instead.
REQ-027 seg SHALL be the registered hex-to-7-segment decode of the selected digit, aligned with an (no skew cycle); values 0-9 SHALL decode as standard numerals.

Reset
REQ-028 Asserting reset SHALL immediately set:
- state=PLAY;
- score=0, high_score=0, lives=LIVES_INIT, level=0, streak=0, game_over=0;
- scan counter=0, digit index=0, an=4'b1110, seg=7'b1000000 (digit "0");
- registered result=0.
REQ-029 Reset asserted mid-game SHALL discard any in-flight event.
REQ-030 After reset deassertion, the first event SHALL require result to be seen at 0 for at least one cycle.

Verification
REQ-031 Reset, then 5 correct events (each a result 0->2->0 pulse) -> score=8'h05, level=1, lives=3, game_over=0.
REQ-032 Reset, then result held at 2 for 10 cycles -> score=8'h01 only.
REQ-033 Drive score to 8'h09, then 1 correct event -> score=8'h10; from 8'h99, 1 correct event -> score stays 8'h99.
REQ-034 Score 8'h07, then 3 incorrect events -> game_over=1, lives=0, high_score=8'h07; further correct events leave score=8'h07.
REQ-035 new_game pulsed in the same cycle as a correct event -> score=0, lives=3, level=0, PLAY state, high_score kept.
REQ-036 SCAN_DIV=4, score=8'h42, level=3, lives=2 -> an cycles 1110,1101,1011,0111 every 4 clks; seg shows 2,4,2,3 in that order.
